life_grid_engine: RTL and testbench
===================================

Name: life_grid_engine

Overview:
Parametrised, row-serial Game of Life engine holding a WIDTH x HEIGHT board in registers. The host loads the board one row per beat, then requests N generations. The engine computes one row of next state per cycle into a shadow board and commits it at the end of each generation. It sits above the per-cell next-state logic and replaces per-cell wiring with a self-contained, host-driven grid.

Parameters:
WIDTH, 8, columns per row (>=3)
HEIGHT, 8, rows in board (>=3)
GEN_W, 16, width of generation request and generation counter

Ports:
CLK  in  1  clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
LOAD_VALID  in  1  host presents a board row
LOAD_READY  out  1  engine accepts a row this cycle
LOAD_ROW  in  WIDTH  row data, bit c = column c
START  in  1  request a run (single-cycle pulse honoured only in IDLE)
GEN_REQ  in  GEN_W  number of generations to run, sampled with START
ABORT  in  1  cancel the current run
BUSY  out  1  run in progress
DONE  out  1  one-cycle pulse when a run completes normally
STABLE  out  1  last committed generation equalled its predecessor
GENERATION  out  GEN_W  generations committed since the last load
GRID  out  WIDTH*HEIGHT  current board, bit r*WIDTH+c

Behaviour:
- Reset (async, RST_N low) values:
  - GRID, shadow board, GENERATION, STABLE, DONE, BUSY, load pointer, row pointer = 0.
  - State = IDLE.
- States: IDLE, COMPUTE, COMMIT.
- LOAD_READY = (state==IDLE) & ~START.
- Load beat: accepted on LOAD_VALID & LOAD_READY.
  - Writes LOAD_ROW to row[load_ptr].
  - load_ptr wraps HEIGHT-1 -> 0.
  - First beat after a wrap (load_ptr==0) clears GENERATION and STABLE.
  - Partial loads are legal; unwritten rows keep their old contents.
- IDLE + START:
  - GEN_REQ==0: stay in IDLE, DONE=1 next cycle, board unchanged.
  - Otherwise: remaining<=GEN_REQ, row_ptr<=0, BUSY=1, go to COMPUTE next cycle.
- COMPUTE, one row per cycle:
  - shadow[row_ptr] <= next-state of GRID rows row_ptr-1, row_ptr, row_ptr+1.
  - Rules: a live cell with 2 or 3 live neighbours lives; a dead cell with exactly 3 lives; all other cells are dead.
  - Neighbours outside the board are dead (see optional feature).
  - After row HEIGHT-1, go to COMMIT.
- COMMIT, one cycle:
  - GRID <= shadow.
  - STABLE <= (shadow==GRID).
  - GENERATION <= GENERATION+1, mod 2^GEN_W wrap.
  - remaining decrements.
  - If remaining reaches 0: go to IDLE, DONE=1 for the following cycle, BUSY=0. Otherwise row_ptr<=0 and go to COMPUTE.
- Latency: HEIGHT+1 cycles per generation; DONE asserts N*(HEIGHT+1)+1 cycles after the START edge.
- BUSY is high in COMPUTE and COMMIT only.
- GRID changes only in COMMIT or on a load beat, never mid-generation.
- ABORT in COMPUTE or COMMIT:
  - Return to IDLE next edge.
  - GRID and GENERATION keep their last committed values; shadow is discarded.
  - No DONE. ABORT has priority over a same-cycle commit.
  - ABORT in IDLE is ignored.
- START while BUSY is ignored. LOAD_VALID while BUSY is stalled (LOAD_READY=0).
- Reset mid-run: everything returns to reset values immediately, including GRID.

Optional Feature:
- Macro: LIFE_TORUS_EN.
- Defined: the board is toroidal. Row -1 is row HEIGHT-1, row HEIGHT is row 0, and columns wrap likewise.
- Undefined: cells beyond any edge read as dead.
- Port list is identical in both builds.

Decomposition:
- Package life_pkg holds:
  - the state enum typedef (IDLE, COMPUTE, COMMIT);
  - the neighbour-count width constant (4 bits);
  - a function giving the next-state rule from ME and the neighbour count.
- One sub-module, life_row_next: purely combinational, WIDTH-parametrised.
  - Inputs: above, current and below rows.
  - Output: next row.
  - Edge/torus handling: the LIFE_TORUS_EN column wrap is applied inside it; the row wrap is applied in the parent.

Test Plan:
- 5x5, blinker loaded at (2,1)(2,2)(2,3), GEN_REQ=1:
  - DONE 7 cycles after START.
  - GRID shows the vertical blinker.
  - GENERATION=1, STABLE=0.
  - GEN_REQ=2 instead returns the original board.
- 2x2 block at (1,1)-(2,2) on 6x6, GEN_REQ=3: GRID unchanged, STABLE=1, GENERATION=3.
- 8x8 glider, GEN_REQ=32:
  - LIFE_TORUS_EN build: the glider returns to its start pattern.
  - Non-torus build: it collapses to a 2x2 block in the corner.
- GEN_REQ=0 with START: DONE next cycle, BUSY never high, GRID and GENERATION unchanged.
- ABORT in the 3rd COMPUTE cycle of generation 2 of 4: IDLE next cycle, no DONE, GRID equals generation 1, GENERATION=1.
- START and LOAD_VALID in the same IDLE cycle: run starts, row not written.
- RST_N low mid-COMPUTE: GRID, GENERATION and BUSY read 0 with no clock edge required.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and the Game of Life cell rule for the grid engine.
package life_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCompute,
        StCommit
    } state_e;

    // Eight neighbours fit in four bits.
    localparam int unsigned CntW = 4;

    // Next state of one cell from its own state and its live-neighbour count.
    function automatic logic next_cell(input logic me, input logic [CntW-1:0] cnt);
        return (cnt == 4'd3) || (me && (cnt == 4'd2));
    endfunction

endpackage

// File: rtl/life_row_next.sv
// Combinational next-state of one board row from the rows above, at and below it.
// Column wrap is selected by LIFE_TORUS_EN; otherwise cells past either edge read as dead.
module life_row_next
    import life_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] above,
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] below,
    output logic [WIDTH-1:0] next_row
);

    // Rows padded with one guard column per side; bit c+1 holds column c.
    logic [WIDTH+1:0] ext_above;
    logic [WIDTH+1:0] ext_cur;
    logic [WIDTH+1:0] ext_below;

`ifdef LIFE_TORUS_EN
    assign ext_above = {above[0], above, above[WIDTH-1]};
    assign ext_cur   = {cur[0],   cur,   cur[WIDTH-1]};
    assign ext_below = {below[0], below, below[WIDTH-1]};
`else
    assign ext_above = {1'b0, above, 1'b0};
    assign ext_cur   = {1'b0, cur,   1'b0};
    assign ext_below = {1'b0, below, 1'b0};
`endif

    // Count the eight neighbours of every column and apply the rule.
    always_comb begin
        logic [CntW-1:0] cnt;
        next_row = '0;
        for (int c = 0; c < int'(WIDTH); c++) begin
            cnt = CntW'(ext_above[c]) + CntW'(ext_above[c+1]) + CntW'(ext_above[c+2])
                + CntW'(ext_cur[c])                           + CntW'(ext_cur[c+2])
                + CntW'(ext_below[c]) + CntW'(ext_below[c+1]) + CntW'(ext_below[c+2]);
            next_row[c] = next_cell(ext_cur[c+1], cnt);
        end
    end

endmodule

// File: rtl/life_grid_engine.sv
// Row-serial Game of Life engine: host loads rows, then requests N generations.
// One shadow row is computed per cycle and the whole board commits at generation end.
// Build option LIFE_TORUS_EN makes the board toroidal (rows and columns wrap).
module life_grid_engine
    import life_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HEIGHT = 8,
    parameter int unsigned GEN_W  = 16
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      LOAD_VALID,
    output logic                      LOAD_READY,
    input  logic [WIDTH-1:0]          LOAD_ROW,
    input  logic                      START,
    input  logic [GEN_W-1:0]          GEN_REQ,
    input  logic                      ABORT,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      STABLE,
    output logic [GEN_W-1:0]          GENERATION,
    output logic [WIDTH*HEIGHT-1:0]   GRID
);

    localparam int unsigned RowW = $clog2(HEIGHT);
    localparam logic [RowW-1:0] LastRow = RowW'(HEIGHT - 1);

    state_e                        state_q, state_d;
    logic [HEIGHT-1:0][WIDTH-1:0]  grid_q, grid_d;
    logic [HEIGHT-1:0][WIDTH-1:0]  shadow_q, shadow_d;
    logic [RowW-1:0]               load_ptr_q, load_ptr_d;
    logic [RowW-1:0]               row_ptr_q, row_ptr_d;
    logic [GEN_W-1:0]              remaining_q, remaining_d;
    logic [GEN_W-1:0]              gen_q, gen_d;
    logic                          stable_q, stable_d;
    logic                          done_q, done_d;

    logic [WIDTH-1:0] row_above, row_cur, row_below, row_next;
    logic             load_fire;

    assign LOAD_READY = (state_q == StIdle) && !START;
    assign load_fire  = LOAD_VALID && LOAD_READY;
    assign BUSY       = (state_q != StIdle);
    assign DONE       = done_q;
    assign STABLE     = stable_q;
    assign GENERATION = gen_q;
    assign GRID       = grid_q;

    // Gather the three committed rows around row_ptr, handling the top and bottom edges.
    always_comb begin
        row_cur = grid_q[row_ptr_q];
        if (row_ptr_q == '0) begin
`ifdef LIFE_TORUS_EN
            row_above = grid_q[HEIGHT-1];
`else
            row_above = '0;
`endif
        end else begin
            row_above = grid_q[row_ptr_q - 1'b1];
        end
        if (row_ptr_q == LastRow) begin
`ifdef LIFE_TORUS_EN
            row_below = grid_q[0];
`else
            row_below = '0;
`endif
        end else begin
            row_below = grid_q[row_ptr_q + 1'b1];
        end
    end

    life_row_next #(
        .WIDTH (WIDTH)
    ) u_row_next (
        .above    (row_above),
        .cur      (row_cur),
        .below    (row_below),
        .next_row (row_next)
    );

    // Next-state: load beats, run start, row compute, commit and abort.
    always_comb begin
        state_d     = state_q;
        grid_d      = grid_q;
        shadow_d    = shadow_q;
        load_ptr_d  = load_ptr_q;
        row_ptr_d   = row_ptr_q;
        remaining_d = remaining_q;
        gen_d       = gen_q;
        stable_d    = stable_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    if (GEN_REQ == '0) begin
                        done_d = 1'b1;
                    end else begin
                        remaining_d = GEN_REQ;
                        row_ptr_d   = '0;
                        state_d     = StCompute;
                    end
                end else if (load_fire) begin
                    grid_d[load_ptr_q] = LOAD_ROW;
                    load_ptr_d = (load_ptr_q == LastRow) ? '0 : load_ptr_q + 1'b1;
                    // A fresh board starts a new generation count.
                    if (load_ptr_q == '0) begin
                        gen_d    = '0;
                        stable_d = 1'b0;
                    end
                end
            end
            StCompute: begin
                if (ABORT) begin
                    state_d = StIdle;
                end else begin
                    shadow_d[row_ptr_q] = row_next;
                    if (row_ptr_q == LastRow) begin
                        state_d = StCommit;
                    end else begin
                        row_ptr_d = row_ptr_q + 1'b1;
                    end
                end
            end
            StCommit: begin
                if (ABORT) begin
                    state_d = StIdle;
                end else begin
                    grid_d      = shadow_q;
                    stable_d    = (shadow_q == grid_q);
                    gen_d       = gen_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == GEN_W'(1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        row_ptr_d = '0;
                        state_d   = StCompute;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            grid_q      <= '0;
            shadow_q    <= '0;
            load_ptr_q  <= '0;
            row_ptr_q   <= '0;
            remaining_q <= '0;
            gen_q       <= '0;
            stable_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grid_q      <= grid_d;
            shadow_q    <= shadow_d;
            load_ptr_q  <= load_ptr_d;
            row_ptr_q   <= row_ptr_d;
            remaining_q <= remaining_d;
            gen_q       <= gen_d;
            stable_q    <= stable_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_life_grid_engine.sv
// Self-checking bench for life_grid_engine on an 8x8 board against a cell-level model.
module tb_life_grid_engine;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int GW = 16;
    localparam int N  = W * H;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          LOAD_VALID;
    logic          LOAD_READY;
    logic [W-1:0]  LOAD_ROW;
    logic          START;
    logic [GW-1:0] GEN_REQ;
    logic          ABORT;
    logic          BUSY;
    logic          DONE;
    logic          STABLE;
    logic [GW-1:0] GENERATION;
    logic [N-1:0]  GRID;

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0] model_grid;
    int           model_gen;
    logic         model_stable;

    life_grid_engine #(
        .WIDTH  (W),
        .HEIGHT (H),
        .GEN_W  (GW)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .LOAD_VALID (LOAD_VALID),
        .LOAD_READY (LOAD_READY),
        .LOAD_ROW   (LOAD_ROW),
        .START      (START),
        .GEN_REQ    (GEN_REQ),
        .ABORT      (ABORT),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .STABLE     (STABLE),
        .GENERATION (GENERATION),
        .GRID       (GRID)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One generation from the rules: count the eight neighbours of every cell directly.
    function automatic logic [N-1:0] life_step(input logic [N-1:0] g);
        logic [N-1:0] nx;
        int cnt, rr, cc;
        nx = '0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr == 0 && dc == 0) continue;
                        rr = r + dr;
                        cc = c + dc;
`ifdef LIFE_TORUS_EN
                        rr = (rr + H) % H;
                        cc = (cc + W) % W;
`else
                        if (rr < 0 || rr >= H || cc < 0 || cc >= W) continue;
`endif
                        cnt += int'(g[rr*W+cc]);
                    end
                end
                nx[r*W+c] = g[r*W+c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
            end
        end
        return nx;
    endfunction

    function automatic void model_advance(input int n);
        logic [N-1:0] prev;
        for (int i = 0; i < n; i++) begin
            prev         = model_grid;
            model_grid   = life_step(prev);
            model_stable = (prev == model_grid);
            model_gen++;
        end
    endfunction

    // Full board load starting at row 0.
    task automatic load_board(input logic [N-1:0] b);
        for (int r = 0; r < H; r++) begin
            LOAD_VALID = 1'b1;
            LOAD_ROW   = b[r*W +: W];
            tick();
        end
        LOAD_VALID   = 1'b0;
        model_grid   = b;
        model_gen    = 0;
        model_stable = 1'b0;
    endtask

    // Pulse START and wait (bounded) for DONE; cyc counts from the START edge.
    task automatic run_gens(input int n, output int cyc);
        int limit;
        limit     = n * (H + 1) + 20;
        GEN_REQ   = GW'(n);
        START     = 1'b1;
        tick();
        START     = 1'b0;
        cyc       = 1;
        while (!DONE && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0; LOAD_VALID = 1'b0; LOAD_ROW = '0; START = 1'b0;
        GEN_REQ = '0; ABORT = 1'b0;
        #12;
        n_checks++;
        if (GRID !== '0) begin n_fail++; $display("FAIL reset_grid: got %h expected 0", GRID); end
        n_checks++;
        if ({BUSY, DONE, STABLE} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000", {BUSY, DONE, STABLE});
        end
        n_checks++;
        if (GENERATION !== '0) begin
            n_fail++; $display("FAIL reset_gen: got %0d expected 0", GENERATION);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        n_checks++;
        if (LOAD_READY !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 1", LOAD_READY);
        end
        model_grid = '0; model_gen = 0; model_stable = 1'b0;
    endtask

    task automatic test_blinker();
        logic [N-1:0] horiz, vert;
        int cyc;
        horiz = '0; horiz[2*W+1] = 1'b1; horiz[2*W+2] = 1'b1; horiz[2*W+3] = 1'b1;
        vert  = '0; vert[1*W+2]  = 1'b1; vert[2*W+2]  = 1'b1; vert[3*W+2]  = 1'b1;
        load_board(horiz);
        run_gens(1, cyc);
        model_advance(1);
        n_checks++;
        if (cyc != 1 * (H + 1) + 1) begin
            n_fail++; $display("FAIL blinker_latency: got %0d expected %0d", cyc, H + 2);
        end
        n_checks++;
        if (GRID !== vert) begin n_fail++; $display("FAIL blinker_g1: got %h expected %h", GRID, vert); end
        n_checks++;
        if (GENERATION !== GW'(1) || STABLE !== 1'b0) begin
            n_fail++; $display("FAIL blinker_gen: got %0d/%b expected 1/0", GENERATION, STABLE);
        end
        tick();
        load_board(horiz);
        run_gens(2, cyc);
        model_advance(2);
        n_checks++;
        if (GRID !== horiz || cyc != 2 * (H + 1) + 1) begin
            n_fail++; $display("FAIL blinker_g2: got %h/%0d expected %h/%0d", GRID, cyc, horiz, 2*H+3);
        end
        tick();
    endtask

    task automatic test_block();
        logic [N-1:0] blk;
        int cyc;
        blk = '0; blk[3*W+3] = 1'b1; blk[3*W+4] = 1'b1; blk[4*W+3] = 1'b1; blk[4*W+4] = 1'b1;
        load_board(blk);
        run_gens(3, cyc);
        model_advance(3);
        n_checks++;
        if (GRID !== blk || STABLE !== 1'b1 || GENERATION !== GW'(3)) begin
            n_fail++;
            $display("FAIL block_still: got %h/%b/%0d expected %h/1/3", GRID, STABLE, GENERATION, blk);
        end
        tick();
    endtask

    task automatic test_glider();
        logic [N-1:0] gl;
        int cyc;
        gl = '0; gl[0*W+1] = 1'b1; gl[1*W+2] = 1'b1;
        gl[2*W+0] = 1'b1; gl[2*W+1] = 1'b1; gl[2*W+2] = 1'b1;
        load_board(gl);
        run_gens(32, cyc);
        model_advance(32);
        n_checks++;
        if (GRID !== model_grid || GENERATION !== GW'(32)) begin
            n_fail++; $display("FAIL glider_32: got %h expected %h", GRID, model_grid);
        end
`ifdef LIFE_TORUS_EN
        n_checks++;
        if (GRID !== gl) begin n_fail++; $display("FAIL glider_home: got %h expected %h", GRID, gl); end
`else
        n_checks++;
        if ($countones(GRID) != 4 || STABLE !== 1'b1) begin
            n_fail++; $display("FAIL glider_block: got %0d cells stable %b expected 4/1",
                               $countones(GRID), STABLE);
        end
`endif
        tick();
    endtask

    task automatic test_zero_gen();
        GEN_REQ = '0;
        START   = 1'b1;
        tick();
        START   = 1'b0;
        n_checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0) begin
            n_fail++; $display("FAIL zero_done: got done %b busy %b expected 1/0", DONE, BUSY);
        end
        tick();
        n_checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b0 || GRID !== model_grid || GENERATION !== GW'(model_gen)) begin
            n_fail++; $display("FAIL zero_hold: got %b%b %h %0d expected 00 %h %0d",
                               DONE, BUSY, GRID, GENERATION, model_grid, model_gen);
        end
    endtask

    task automatic test_abort();
        logic [N-1:0] b, g1;
        int seen_done;
        b = {$urandom, $urandom};
        load_board(b);
        g1 = life_step(b);
        GEN_REQ = GW'(4);
        START   = 1'b1;
        tick();
        START   = 1'b0;
        // Generation 1 takes H+1 edges; two more edges land in the 3rd compute cycle of gen 2.
        for (int i = 0; i < H + 3; i++) tick();
        n_checks++;
        if (GRID !== g1 || BUSY !== 1'b1) begin
            n_fail++; $display("FAIL abort_mid: got %h busy %b expected %h busy 1", GRID, BUSY, g1);
        end
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        n_checks++;
        if (BUSY !== 1'b0 || GRID !== g1 || GENERATION !== GW'(1) || DONE !== 1'b0) begin
            n_fail++; $display("FAIL abort_state: got busy %b %h gen %0d done %b expected 0 %h 1 0",
                               BUSY, GRID, GENERATION, DONE, g1);
        end
        seen_done = 0;
        for (int i = 0; i < 2 * (H + 1); i++) begin
            tick();
            if (DONE === 1'b1) seen_done++;
        end
        n_checks++;
        if (seen_done != 0) begin n_fail++; $display("FAIL abort_nodone: got %0d expected 0", seen_done); end
        model_grid = g1; model_gen = 1; model_stable = (g1 == b);
    endtask

    task automatic test_start_with_load();
        logic [N-1:0] b;
        int cyc;
        b = {$urandom, $urandom};
        load_board(b);
        LOAD_VALID = 1'b1;
        LOAD_ROW   = ~b[W-1:0];
        GEN_REQ    = GW'(1);
        START      = 1'b1;
        #1;
        n_checks++;
        if (LOAD_READY !== 1'b0) begin
            n_fail++; $display("FAIL start_load_ready: got %b expected 0", LOAD_READY);
        end
        tick();
        START      = 1'b0;
        LOAD_VALID = 1'b0;
        cyc = 1;
        while (!DONE && cyc < H + 20) begin tick(); cyc++; end
        model_advance(1);
        n_checks++;
        if (GRID !== model_grid || GENERATION !== GW'(1) || cyc != H + 2) begin
            n_fail++; $display("FAIL start_load_run: got %h %0d cyc %0d expected %h 1 cyc %0d",
                               GRID, GENERATION, cyc, model_grid, H + 2);
        end
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] b;
        int n, cyc;
        for (int it = 0; it < 6; it++) begin
            b = {$urandom, $urandom} | {$urandom, $urandom};
            load_board(b);
            n = int'($urandom_range(1, 5));
            run_gens(n, cyc);
            model_advance(n);
            n_checks++;
            if (cyc != n * (H + 1) + 1 || GRID !== model_grid || GENERATION !== GW'(model_gen)
                || STABLE !== model_stable) begin
                n_fail++;
                $display("FAIL random_%0d: got cyc %0d %h gen %0d st %b expected %0d %h %0d %b", it,
                         cyc, GRID, GENERATION, STABLE, n*(H+1)+1, model_grid, model_gen, model_stable);
            end
            tick();
            // Continue without reloading: the count keeps accumulating.
            n = int'($urandom_range(1, 3));
            run_gens(n, cyc);
            model_advance(n);
            n_checks++;
            if (GRID !== model_grid || GENERATION !== GW'(model_gen) || STABLE !== model_stable) begin
                n_fail++; $display("FAIL random_cont_%0d: got %h %0d %b expected %h %0d %b", it,
                                   GRID, GENERATION, STABLE, model_grid, model_gen, model_stable);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_run();
        logic [N-1:0] b;
        b = {$urandom, $urandom};
        load_board(b);
        GEN_REQ = GW'(3);
        START   = 1'b1;
        tick();
        START   = 1'b0;
        for (int i = 0; i < H + 3; i++) tick();
        #2;
        RST_N = 1'b0;
        #1;
        n_checks++;
        if (GRID !== '0 || GENERATION !== '0 || BUSY !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: got %h gen %0d busy %b expected 0 0 0",
                               GRID, GENERATION, BUSY);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        model_grid = '0; model_gen = 0; model_stable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_blinker();
        test_block();
        test_glider();
        test_zero_gen();
        test_abort();
        test_start_with_load();
        test_random();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
